expr_eval: RTL and testbench
============================

// Module: expr_eval
// PURPOSE
//   Downstream consumer of the ASCII expression character stream (digits, '+', '*').
//   Evaluates single-digit infix expressions with '*' binding tighter than '+'.
//   '=' terminates an expression; a malformed one reports err.
//   Feeds the result/flag to the display/console stage via a valid/ready handshake.
// PARAMETERS
//   WIDTH  16  result width; all arithmetic is modulo 2^WIDTH
// PORTS
//   clk        in   1      single clock, rising edge
//   clr        in   1      reset: asynchronous, active-high
//   in         in   8      ASCII character
//   in_valid   in   1      in carries a character this cycle
//   in_ready   out  1      block accepts in this cycle; low while a result is held
//   res        out  WIDTH  expression value (0 when err)
//   res_valid  out  1      res/err valid; held until res_ready
//   res_ready  in   1      downstream takes result
//   err        out  1      expression malformed; qualified by res_valid
//   ovf        out  1      (EXPR_OVF_EN only) arithmetic wrapped; qualified by res_valid
// BEHAVIOUR
//   Reset: state=IDLE, sum=0, term=0, mul=0, res=0, res_valid=0, err=0, ovf=0; in_ready=1.
//   Character accepted when in_valid & in_ready; one character per cycle max.
//   States:
//     IDLE  expect digit: digit d -> term=d, OPND
//     OPND  expect op/'=': '+' -> sum+=term, mul=0, OPER; '*' -> mul=1, OPER
//                          '=' -> res=sum+term, DONE
//     OPER  expect digit: digit d -> term = mul ? term*d : d, OPND
//     ERR   discard chars until '=' -> res=0, err=1, DONE
//     DONE  res_valid=1, in_ready=0; on res_ready -> IDLE, sum=term=mul=0, err=ovf=0
//   Error transitions:
//     any non-digit in IDLE/OPER; any char outside {0-9,+,*,=} in OPND -> ERR
//     '=' in IDLE/OPER -> DONE with err=1 directly, no ERR visit
//   Latency: res_valid rises the cycle after '=' is accepted (registered output).
//   res_valid falls the cycle after the res_ready handshake.
//   No character can arrive in the handshake cycle (in_ready=0 in DONE).
//   Arithmetic: term*d and sum+term truncated to WIDTH bits; the product uses a
//     2*WIDTH intermediate, low WIDTH bits kept.
//   Empty expression ("=" alone) -> err=1, res=0.
//   clr mid-expression or mid-DONE returns to reset values immediately; a held
//     result is lost.
// CONFIGURATION
//   EXPR_OVF_EN defined:
//     ovf port present; set when any multiply or add result exceeds 2^WIDTH-1
//       (sticky per expression)
//     ovf cleared with err on handshake; ovf=0 whenever err=1
//   EXPR_OVF_EN undefined:
//     ovf port and its logic absent; wrap is silent
// STRUCTURE
//   expr_pkg:
//     state encodings IDLE/OPND/OPER/ERR/DONE
//     ASCII constants CH_0, CH_9, CH_ADD, CH_MUL, CH_EQ
//   Sub-module ascii_class (combinational), outputs:
//     is_digit, is_add, is_mul, is_eq, digit value [3:0]
//   Top holds the FSM, sum/term/mul datapath and output registers.
// TESTING
//   "1+2*3=" with res_ready=1 -> res=7, err=0; res_valid one cycle after '='
//   "2*3*4+5=" then hold res_ready=0 for 5 cycles:
//     -> res=29 held, in_ready=0 throughout; IDLE after the handshake
//   "1++2=" -> res_valid with err=1, res=0; next "9=" -> res=9, err=0
//   "=" alone, and "3+=" -> err=1 each, res=0
//   "9*9*9*9*9=" with WIDTH=8 -> res=59049 mod 256=169
//     EXPR_OVF_EN: ovf=1; without it: no ovf port
//   Pulse clr after "4*" mid-expression, then "5=" -> res=5, err=0

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants for the ASCII expression evaluator:
// FSM state encodings and the character codes it recognises.
package expr_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] OPND = 3'd1;
    localparam logic [2:0] OPER = 3'd2;
    localparam logic [2:0] ERR  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_EQ  = 8'h3D;

endpackage

// File: rtl/expr_eval_ascii_class.sv
// Combinational ASCII classifier for the expression evaluator.
// Ports: ch (in, 8) -> is_digit/is_add/is_mul/is_eq flags, digit value [3:0].
module ascii_class
    import expr_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic       is_add,
    output logic       is_mul,
    output logic       is_eq,
    output logic [3:0] digit
);

    assign is_digit = (ch >= CH_0) && (ch <= CH_9);
    assign is_add   = (ch == CH_ADD);
    assign is_mul   = (ch == CH_MUL);
    assign is_eq    = (ch == CH_EQ);
    // '0'..'9' are 0x30..0x39, so the low nibble is the value
    assign digit    = ch[3:0];

endmodule

// File: rtl/expr_eval.sv
// Single-digit infix evaluator ('*' before '+', '=' ends) with a
// valid/ready result port. Ports: clk, clr (async high), in/in_valid/
// in_ready, res/res_valid/res_ready, err; ovf only with EXPR_OVF_EN.
module expr_eval
    import expr_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             err
`ifdef EXPR_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [2:0]       state;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] term;
    logic             mul;

    logic             is_digit;
    logic             is_add;
    logic             is_mul;
    logic             is_eq;
    logic [3:0]       dval;
    logic [WIDTH-1:0] d_ext;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] sum_nx;

    ascii_class u_class (
        .ch       (in),
        .is_digit (is_digit),
        .is_add   (is_add),
        .is_mul   (is_mul),
        .is_eq    (is_eq),
        .digit    (dval)
    );

    assign in_ready = (state != DONE);
    assign d_ext    = {{(WIDTH-4){1'b0}}, dval};

`ifdef EXPR_OVF_EN
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH:0]     add_w;
    logic               prod_ovf;
    logic               add_ovf;

    assign prod_w   = {{WIDTH{1'b0}}, term}
                    * {{(2*WIDTH-4){1'b0}}, dval};
    assign add_w    = {1'b0, sum} + {1'b0, term};
    assign prod     = prod_w[WIDTH-1:0];
    assign sum_nx   = add_w[WIDTH-1:0];
    assign prod_ovf = |prod_w[2*WIDTH-1:WIDTH];
    assign add_ovf  = add_w[WIDTH];
`else
    // low WIDTH bits of the product are all that survive the wrap
    assign prod   = term * d_ext;
    assign sum_nx = sum + term;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            sum       <= '0;
            term      <= '0;
            mul       <= 1'b0;
            res       <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else if (state == DONE) begin
            if (res_ready) begin
                state     <= IDLE;
                sum       <= '0;
                term      <= '0;
                mul       <= 1'b0;
                res_valid <= 1'b0;
                err       <= 1'b0;
            end
        end else if (in_valid) begin
            unique case (state)
                IDLE, OPER: begin
                    unique case (1'b1)
                        is_digit: begin
                            term  <= (state == OPER && mul) ? prod : d_ext;
                            state <= OPND;
                        end
                        is_eq: begin
                            res       <= '0;
                            err       <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                        default: state <= ERR;
                    endcase
                end
                OPND: begin
                    unique case (1'b1)
                        is_add: begin
                            sum   <= sum_nx;
                            mul   <= 1'b0;
                            state <= OPER;
                        end
                        is_mul: begin
                            mul   <= 1'b1;
                            state <= OPER;
                        end
                        is_eq: begin
                            res       <= sum_nx;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                        default: state <= ERR;
                    endcase
                end
                ERR: begin
                    if (is_eq) begin
                        res       <= '0;
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXPR_OVF_EN
    // sticky per expression; any error ending forces it back to 0
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ovf <= 1'b0;
        end else if (state == DONE) begin
            if (res_ready) ovf <= 1'b0;
        end else if (in_valid) begin
            if (state == OPND && (is_add || is_eq))
                ovf <= ovf | add_ovf;
            else if (state == OPER && is_digit && mul)
                ovf <= ovf | prod_ovf;
            else if (is_eq)
                ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval (WIDTH=8): directed cases,
// back-pressure, clr recovery and random expressions vs a model.
module tb_expr_eval;

    localparam int W = 8;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         clr;
    logic [7:0]   in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] res;
    logic         res_valid;
    logic         res_ready;
    logic         err;
`ifdef EXPR_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    expr_eval #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err       (err)
`ifdef EXPR_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Exact evaluation of the text before the first '=', reduced mod 2^W.
    function automatic void model(input byte unsigned q[$],
                                  output logic [W-1:0] r,
                                  output logic e,
                                  output logic o);
        int n;
        bit ok;
        longint acc;
        longint prod;
        n = 0;
        while (n < q.size() && q[n] != 8'h3D) n++;
        ok = (n % 2 == 1);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0)
                ok = ok && (q[i] >= 8'h30) && (q[i] <= 8'h39);
            else
                ok = ok && (q[i] == 8'h2B || q[i] == 8'h2A);
        end
        r = '0;
        e = !ok;
        o = 1'b0;
        if (ok) begin
            acc  = 0;
            prod = longint'(q[0]) - 48;
            for (int i = 1; i < n; i += 2) begin
                if (q[i] == 8'h2A) begin
                    prod = prod * (longint'(q[i+1]) - 48);
                    if (prod > MAXV) o = 1'b1;
                end else begin
                    acc = acc + prod;
                    if (acc > MAXV) o = 1'b1;
                    prod = longint'(q[i+1]) - 48;
                end
            end
            acc = acc + prod;
            if (acc > MAXV) o = 1'b1;
            r = acc[W-1:0];
        end
    endfunction

    task automatic send_ch(input byte unsigned c, input string name);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready got=%b want=1", name, in_ready);
        end
        in       = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_expr(input string name, input byte unsigned q[$],
                            input int hold, input int gap,
                            input logic [W-1:0] wr, input logic we,
                            input logic wo);
        res_ready = (hold == 0);
        for (int i = 0; i < q.size(); i++) begin
            send_ch(q[i], name);
            if (i != q.size() - 1 && gap > 0) begin
                repeat ($urandom_range(0, gap)) @(posedge clk);
                #1;
            end
        end
        total++;
        if (res_valid !== 1'b1 || res !== wr || err !== we) begin
            bad++;
            $display("FAIL %s result got v=%b res=%0d err=%b want v=1 res=%0d err=%b",
                     name, res_valid, res, err, wr, we);
        end
`ifdef EXPR_OVF_EN
        total++;
        if (ovf !== wo) begin
            bad++;
            $display("FAIL %s ovf got=%b want=%b", name, ovf, wo);
        end
`endif
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res !== wr) begin
                bad++;
                $display("FAIL %s hold%0d got v=%b rdy=%b res=%0d want v=1 rdy=0 res=%0d",
                         name, k, res_valid, in_ready, res, wr);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s release got v=%b rdy=%b err=%b want v=0 rdy=1 err=0",
                     name, res_valid, in_ready, err);
        end
    endtask

    task automatic run_str(input string s, input int hold,
                           input logic [W-1:0] wr, input logic we,
                           input logic wo);
        byte unsigned q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        run_expr(s, q, hold, 0, wr, we, wo);
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        in        = 8'h00;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        total++;
        if (res_valid !== 1'b0 || err !== 1'b0 || res !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset got v=%b err=%b res=%0d rdy=%b want 0 0 0 1",
                     res_valid, err, res, in_ready);
        end
`ifdef EXPR_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset ovf got=%b want=0", ovf);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_str("1+2*3=", 0, 8'd7, 1'b0, 1'b0);
        run_str("2*3*4+5=", 5, 8'd29, 1'b0, 1'b0);
        run_str("1++2=", 0, 8'd0, 1'b1, 1'b0);
        run_str("9=", 0, 8'd9, 1'b0, 1'b0);
        run_str("=", 1, 8'd0, 1'b1, 1'b0);
        run_str("3+=", 0, 8'd0, 1'b1, 1'b0);
        run_str("9*9*9*9*9=", 2, 8'd169, 1'b0, 1'b1);
        run_str("9*9*9*9*9+x1=", 0, 8'd0, 1'b1, 1'b0);
        run_str("8*8+7*9=", 0, 8'd127, 1'b0, 1'b0);
        run_str("9*9*4+9*9*4=", 0, 8'd136, 1'b0, 1'b1);
    endtask

    task automatic test_clr();
        send_ch(8'h34, "clr_pre");
        send_ch(8'h2A, "clr_pre");
        #2 clr = 1'b1;
        #2 clr = 1'b0;
        total++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_mid got rdy=%b v=%b want 1 0", in_ready, res_valid);
        end
        @(posedge clk);
        #1;
        run_str("5=", 0, 8'd5, 1'b0, 1'b0);
        send_ch(8'h37, "clr_done");
        send_ch(8'h3D, "clr_done");
        #2 clr = 1'b1;
        #2 clr = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || res !== '0) begin
            bad++;
            $display("FAIL clr_done got v=%b rdy=%b res=%0d want 0 1 0",
                     res_valid, in_ready, res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        byte unsigned gtab [6] = '{8'h61, 8'h2B, 8'h2A, 8'h35, 8'h20, 8'h23};
        for (int t = 0; t < 60; t++) begin
            byte unsigned q[$];
            logic [W-1:0] r;
            logic e;
            logic o;
            int nd;
            nd = $urandom_range(1, 6);
            q.push_back(8'(48 + $urandom_range(0, 9)));
            for (int k = 1; k < nd; k++) begin
                q.push_back($urandom_range(0, 1) ? 8'h2B : 8'h2A);
                q.push_back(8'(48 + $urandom_range(0, 9)));
            end
            if ($urandom_range(0, 3) == 0)
                q[$urandom_range(0, q.size() - 1)] = gtab[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0 && q.size() > 1)
                void'(q.pop_back());
            q.push_back(8'h3D);
            model(q, r, e, o);
            run_expr($sformatf("rand%0d", t), q, $urandom_range(0, 3),
                     $urandom_range(0, 2), r, e, o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
